// File: rtl/bpu_pkg.sv
// Shared branch-predictor types, constants and helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
`ifndef _BHT_DATA_WIDTH
`define _BHT_DATA_WIDTH 8
`endif

package bpu_pkg;

  typedef logic [1:0] pht_cnt_t;

  localparam pht_cnt_t PHT_CNT_INIT = 2'b01;
  localparam pht_cnt_t PHT_CNT_MAX  = 2'b11;
  localparam pht_cnt_t PHT_CNT_MIN  = 2'b00;

  typedef enum logic {
    PHT_ST_INIT,
    PHT_ST_READY
  } pht_state_e;

  // Saturating 2-bit step: taken moves toward strong-T, not-taken toward strong-NT.
  function automatic pht_cnt_t pht_cnt_next(input pht_cnt_t cnt, input logic taken);
    pht_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != PHT_CNT_MAX) nxt = cnt + 2'd1;
    end else begin
      if (cnt != PHT_CNT_MIN) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pht_ram.sv
// 1R1W counter array, depth 2^ADDR_WIDTH x 2 bits, synchronous read.
// Latency: read data valid 1 cycle after re; write lands at the clock edge.
// Backpressure: none; read data holds while re is low, same-address read returns old data.
module pht_ram
  import bpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output pht_cnt_t              rdata,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  pht_cnt_t              wdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  pht_cnt_t mem [DEPTH];

  // Array write; contents are established by the post-reset sweep, not by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its last value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= PHT_CNT_INIT;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pht.sv
// Pattern history table: 2-bit saturating counters indexed by pc ^ bhr; PHT_BYPASS_EN forwards U1 writes to reads.
// Latency: prediction 1 cycle after rd_valid; update written at end of the cycle after upd_valid.
// Backpressure: none; rd_valid/upd_valid are dropped while init_busy is high during the clear sweep.
module pht
  import bpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int HIST_WIDTH = `_BHT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  input  logic                  rd_valid,
  input  logic [31:0]           rd_pc,
  input  logic [HIST_WIDTH-1:0] rd_hist,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [1:0]            pred_cnt,
  input  logic                  upd_valid,
  input  logic [31:0]           upd_pc,
  input  logic [HIST_WIDTH-1:0] upd_hist,
  input  logic                  upd_taken
);

  typedef logic [ADDR_WIDTH-1:0] idx_t;

  // Index hash shared by lookups and updates; history is zero-extended.
  function automatic idx_t pht_hash(input logic [31:0] pc, input logic [HIST_WIDTH-1:0] hist);
    idx_t hext;
    hext = '0;
    hext[HIST_WIDTH-1:0] = hist;
    return pc[ADDR_WIDTH+2:3] ^ hext;
  endfunction

  pht_state_e state_q, state_d;
  idx_t       sweep_q, sweep_d;
  logic       ready;

  idx_t       rd_idx, upd_idx;
  logic       rd_fire, upd_fire;

  logic       u1_vld;
  idx_t       u1_idx;
  logic       u1_taken;
  logic       fwd_hit;
  pht_cnt_t   fwd_cnt;
  pht_cnt_t   u1_old, u1_new;

  pht_cnt_t   rd_rdata, upd_rdata;
  logic       wr_en;
  idx_t       wr_addr;
  pht_cnt_t   wr_data;

  logic       unused_pc;
  assign unused_pc = ^{rd_pc, upd_pc};

  assign ready    = (state_q == PHT_ST_READY);
  assign rd_idx   = pht_hash(rd_pc, rd_hist);
  assign upd_idx  = pht_hash(upd_pc, upd_hist);
  assign rd_fire  = rd_valid & ready;
  assign upd_fire = upd_valid & ready;

  // Sweep state and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PHT_ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Sweep FSM: walk every entry once, then stay READY until reset.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    init_busy = 1'b0;
    case (state_q)
      PHT_ST_INIT: begin
        init_busy = 1'b1;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = PHT_ST_READY;
      end
      PHT_ST_READY: begin
        state_d = PHT_ST_READY;
      end
      default: begin
        state_d = PHT_ST_INIT;
      end
    endcase
  end

  // U0 -> U1: capture the update and note whether the update now in U1 hits the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u1_vld   <= 1'b0;
      u1_idx   <= '0;
      u1_taken <= 1'b0;
      fwd_hit  <= 1'b0;
      fwd_cnt  <= PHT_CNT_INIT;
    end else begin
      u1_vld <= upd_fire;
      if (upd_fire) begin
        u1_idx   <= upd_idx;
        u1_taken <= upd_taken;
        fwd_hit  <= u1_vld && (u1_idx == upd_idx);
        fwd_cnt  <= u1_new;
      end
    end
  end

  // U1: the array read is stale when the previous update wrote this entry, so take its result instead.
  always_comb begin
    u1_old = fwd_hit ? fwd_cnt : upd_rdata;
    u1_new = pht_cnt_next(u1_old, u1_taken);
  end

  // Single write port shared between the clear sweep and U1 writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sweep_q;
    wr_data = PHT_CNT_INIT;
    if (!ready) begin
      wr_en = 1'b1;
    end else if (u1_vld) begin
      wr_en   = 1'b1;
      wr_addr = u1_idx;
      wr_data = u1_new;
    end
  end

  // Two array copies written identically so lookup and update reads never contend.
  pht_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .re    (rd_fire),
    .raddr (rd_idx),
    .rdata (rd_rdata),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data)
  );

  pht_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram_upd (
    .clk   (clk),
    .rst_n (rst_n),
    .re    (upd_fire),
    .raddr (upd_idx),
    .rdata (upd_rdata),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data)
  );

  // Prediction valid strobe, one cycle after an accepted lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
    end else begin
      pred_valid <= rd_fire;
    end
  end

`ifdef PHT_BYPASS_EN
  logic     byp_q;
  pht_cnt_t byp_cnt_q;

  // Capture the U1 result when a lookup hits the entry being written this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q     <= 1'b0;
      byp_cnt_q <= PHT_CNT_INIT;
    end else if (rd_fire) begin
      byp_q     <= u1_vld && (u1_idx == rd_idx);
      byp_cnt_q <= u1_new;
    end
  end

  assign pred_cnt = byp_q ? byp_cnt_q : rd_rdata;
`else
  assign pred_cnt = rd_rdata;
`endif

  assign pred_taken = pred_cnt[1];

endmodule
